// File: rtl/cnn_sched_pkg.sv
// -----------------------------------------------------------------------------
// cnn_sched_pkg
// Types and helpers shared by the CNN frame scheduler.
//   sched_state_t : scheduler FSM states (IDLE, STREAM, DRAIN)
//   frame_pixels  : pixel count of one square frame
// -----------------------------------------------------------------------------
package cnn_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } sched_state_t;

  function automatic int frame_pixels(input int image_width);
    return image_width * image_width;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational rotating-priority arbiter. The search starts at ptr
// and walks upward, wrapping at NumSources. The first requesting source wins.
// Ports:
//   req [NumSources] : request vector
//   ptr [SrcW]       : index that has the highest priority this cycle
//   gnt [NumSources] : one-hot winner (zero when req is zero)
//   idx [SrcW]       : index of the winner (zero when req is zero)
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter  int NumSources = 2,
  localparam int SrcW       = $clog2(NumSources)
) (
  input  logic [NumSources-1:0] req,
  input  logic [SrcW-1:0]       ptr,
  output logic [NumSources-1:0] gnt,
  output logic [SrcW-1:0]       idx
);

  logic found;
  int   cand;

  always_comb begin
    // NOTE: every output gets a default before any branch, so no path through
    // this block leaves a signal unassigned and no latch is inferred.
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int i = 0; i < NumSources; i++) begin
      cand = (int'(ptr) + i) % NumSources;
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = SrcW'(cand);
      end
    end
  end

endmodule

// File: rtl/cnn_frame_scheduler.sv
// -----------------------------------------------------------------------------
// cnn_frame_scheduler
// Shares one CNN conv/pool pipeline between NumSources image requesters. One
// requester owns the pipeline per frame (round-robin). The owner's pixels are
// forwarded through a one-cycle output register until a full frame has been
// accepted; the grant is then held until the pipeline reports set completion.
//
// Optional feature (macro CNN_SCHED_WATCHDOG_EN): adds parameter
// WatchdogCycles and sticky output wdog_timeout. A frame waiting in DRAIN for
// WatchdogCycles cycles without cnn_set_done is force-retired.
//
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   req             : per-source frame request (level)
//   src_valid/data  : per-source pixel stream; src_ready is the accept
//   grant           : one-hot pipeline owner, zero when idle
//   cnn_in_valid/data : registered pixel stream to the pipeline
//   cnn_out_ready   : pipeline can accept a pixel this cycle
//   cnn_set_done    : pipeline pulse, current frame fully processed
//   frame_done      : one-cycle pulse when a frame retires
//   frame_src       : source of the retired frame, valid with frame_done
//   busy            : scheduler is not idle
//   proto_err       : sticky, cnn_set_done seen outside DRAIN
// -----------------------------------------------------------------------------
module cnn_frame_scheduler
  import cnn_sched_pkg::*;
#(
  parameter  int NumSources     = 2,
  parameter  int BitSize        = 8,
  parameter  int ImageWidth     = 32,
`ifdef CNN_SCHED_WATCHDOG_EN
  parameter  int WatchdogCycles = 65535,
`endif
  localparam int SrcW           = $clog2(NumSources),
  localparam int CntW           = $clog2(ImageWidth * ImageWidth + 1)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NumSources-1:0]              req,
  input  logic [NumSources-1:0]              src_valid,
  input  logic [NumSources-1:0][BitSize-1:0] src_data,
  output logic [NumSources-1:0]              src_ready,
  output logic [NumSources-1:0]              grant,
  output logic                               cnn_in_valid,
  output logic [BitSize-1:0]                 cnn_in_data,
  input  logic                               cnn_out_ready,
  input  logic                               cnn_set_done,
  output logic                               frame_done,
  output logic [SrcW-1:0]                    frame_src,
  output logic                               busy,
  output logic                               proto_err
`ifdef CNN_SCHED_WATCHDOG_EN
  ,
  output logic                               wdog_timeout
`endif
);

  localparam int              FramePix = frame_pixels(ImageWidth);
  localparam logic [CntW-1:0] LastPix  = CntW'(FramePix - 1);

  sched_state_t          state_q, state_d;
  logic [SrcW-1:0]       ptr_q, ptr_d;
  logic [SrcW-1:0]       owner_q, owner_d;
  logic [NumSources-1:0] grant_q, grant_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  in_valid_q, in_valid_d;
  logic [BitSize-1:0]    in_data_q, in_data_d;
  logic                  frame_done_q, frame_done_d;
  logic [SrcW-1:0]       frame_src_q, frame_src_d;
  logic                  proto_err_q, proto_err_d;

  logic [NumSources-1:0] arb_gnt;
  logic [SrcW-1:0]       arb_idx;
  logic                  accept;
  logic                  retire;
  logic                  wdog_expire;

  rr_arbiter #(
    .NumSources(NumSources)
  ) u_rr_arbiter (
    .req(req),
    .ptr(ptr_q),
    .gnt(arb_gnt),
    .idx(arb_idx)
  );

  // Only the owner sees ready, and only while pixels are still owed.
  always_comb begin
    src_ready = '0;
    if (state_q == STREAM) src_ready[owner_q] = cnn_out_ready;
  end

  assign accept = (state_q == STREAM) && src_valid[owner_q] && cnn_out_ready;

`ifdef CNN_SCHED_WATCHDOG_EN
  localparam int WdW = $clog2(WatchdogCycles + 1);

  logic [WdW-1:0] wdog_cnt_q, wdog_cnt_d;
  logic           wdog_timeout_q, wdog_timeout_d;

  // Counter is held at zero outside DRAIN so it restarts on every entry.
  always_comb begin
    wdog_cnt_d     = '0;
    wdog_expire    = 1'b0;
    if (state_q == DRAIN) begin
      wdog_cnt_d  = wdog_cnt_q + 1'b1;
      wdog_expire = !cnn_set_done && (wdog_cnt_q == WdW'(WatchdogCycles - 1));
    end
    wdog_timeout_d = wdog_timeout_q | wdog_expire;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_cnt_q     <= '0;
      wdog_timeout_q <= 1'b0;
    end else begin
      wdog_cnt_q     <= wdog_cnt_d;
      wdog_timeout_q <= wdog_timeout_d;
    end
  end

  assign wdog_timeout = wdog_timeout_q;
`else
  assign wdog_expire = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    owner_d      = owner_q;
    grant_d      = grant_q;
    cnt_d        = cnt_q;
    in_valid_d   = accept;
    in_data_d    = accept ? src_data[owner_q] : in_data_q;
    frame_done_d = 1'b0;
    frame_src_d  = frame_src_q;
    // A completion pulse is only legal once the whole frame has been sent,
    // including when it coincides with the final accept.
    proto_err_d  = proto_err_q | (cnn_set_done && (state_q != DRAIN));
    retire       = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (|req) begin
          grant_d = arb_gnt;
          owner_d = arb_idx;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (accept) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LastPix) state_d = DRAIN;
        end
      end
      DRAIN: begin
        retire = cnn_set_done || wdog_expire;
      end
      default: state_d = IDLE;
    endcase

    if (retire) begin
      frame_done_d = 1'b1;
      frame_src_d  = owner_q;
      ptr_d        = (owner_q == SrcW'(NumSources - 1)) ? '0 : owner_q + 1'b1;
      grant_d      = '0;
      state_d      = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      owner_q      <= '0;
      grant_q      <= '0;
      cnt_q        <= '0;
      in_valid_q   <= 1'b0;
      in_data_q    <= '0;
      frame_done_q <= 1'b0;
      frame_src_q  <= '0;
      proto_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      owner_q      <= owner_d;
      grant_q      <= grant_d;
      cnt_q        <= cnt_d;
      in_valid_q   <= in_valid_d;
      in_data_q    <= in_data_d;
      frame_done_q <= frame_done_d;
      frame_src_q  <= frame_src_d;
      proto_err_q  <= proto_err_d;
    end
  end

  assign grant        = grant_q;
  assign cnn_in_valid = in_valid_q;
  assign cnn_in_data  = in_data_q;
  assign frame_done   = frame_done_q;
  assign frame_src    = frame_src_q;
  assign busy         = (state_q != IDLE);
  assign proto_err    = proto_err_q;

endmodule
